// File: rtl/f_mult_iter_pkg.sv
// Shared definitions for the iterative FP64 multiplier: binary64 field widths,
// exponent bias, canonical quiet NaN and the sequencing state enum.
package f_mult_iter_pkg;

    localparam int unsigned FLEN     = 64;
    localparam int unsigned SIGN_W   = 1;
    localparam int unsigned EXP_W    = 11;
    localparam int unsigned FRAC_W   = 52;
    localparam int unsigned SIG_W    = FRAC_W + 1;     // significand incl. hidden bit
    localparam int unsigned PROD_W   = 2 * SIG_W;      // full significand product
    localparam int unsigned EXPS_W   = 13;             // signed working exponent
    localparam int unsigned EXP_BIAS = 1023;

    localparam logic [FLEN-1:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_NORM
    } state_e;

endpackage

// File: rtl/f_classify.sv
// Combinational unpack of one binary64 operand.
// Ports:
//   op_i      : IEEE-754 binary64 operand
//   sign_o    : sign bit
//   exp_o     : effective biased exponent (1 for zero/subnormal encodings)
//   sig_o     : 53-bit significand with hidden bit (0 for zero/subnormal)
//   is_zero_o : +/-0
//   is_sub_o  : subnormal
//   is_inf_o  : +/-Inf
//   is_nan_o  : any NaN
module f_classify
    import f_mult_iter_pkg::*;
(
    input  logic [FLEN-1:0]  op_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [SIG_W-1:0] sig_o,
    output logic             is_zero_o,
    output logic             is_sub_o,
    output logic             is_inf_o,
    output logic             is_nan_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic              exp_zero;
    logic              exp_ones;
    logic              frac_zero;

    assign exp_f     = op_i[FLEN-2 -: EXP_W];
    assign frac_f    = op_i[FRAC_W-1:0];
    assign exp_zero  = ~|exp_f;
    assign exp_ones  = &exp_f;
    assign frac_zero = ~|frac_f;

    assign sign_o    = op_i[FLEN-1];
    assign exp_o     = exp_zero ? EXP_W'(1) : exp_f;
    assign sig_o     = {~exp_zero, frac_f};
    assign is_zero_o = exp_zero & frac_zero;
    assign is_sub_o  = exp_zero & ~frac_zero;
    assign is_inf_o  = exp_ones & frac_zero;
    assign is_nan_o  = exp_ones & ~frac_zero;

endmodule

// File: rtl/f_mult_iter.sv
// Iterative FP64 multiplier, responder side of the up_valid/down_valid/busy
// handshake. One operation at a time, fixed latency of N+1 cycles where
// N = ceil(53/STEP) shift-add cycles followed by one normalise/round cycle.
// Optional build macro: F_MULT_ITER_SUBNORMAL_EN (gradual underflow support;
// when undefined subnormal inputs and sub-2^-1022 results become signed zero).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   a, b       : binary64 operands, captured on accept
//   up_valid   : request, sampled only while idle
//   res        : product, held until the next result
//   down_valid : one-cycle pulse marking res/error valid
//   busy       : high while an operation is in flight
//   error      : NaN/Inf operand or overflow, valid with down_valid
module f_mult_iter
    import f_mult_iter_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    input  logic            up_valid,
    output logic [FLEN-1:0] res,
    output logic            down_valid,
    output logic            busy,
    output logic            error
);

    localparam int unsigned N     = (SIG_W + STEP - 1) / STEP;
    localparam int unsigned BW    = N * STEP;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned RE_W  = EXPS_W - 1;

    // operand unpack
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [SIG_W-1:0] a_sig, b_sig;
    logic             a_zero, a_sub, a_inf, a_nan;
    logic             b_zero, b_sub, b_inf, b_nan;

    f_classify u_cls_a (
        .op_i      (a),
        .sign_o    (a_sign),
        .exp_o     (a_exp),
        .sig_o     (a_sig),
        .is_zero_o (a_zero),
        .is_sub_o  (a_sub),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan)
    );

    f_classify u_cls_b (
        .op_i      (b),
        .sign_o    (b_sign),
        .exp_o     (b_exp),
        .sig_o     (b_sig),
        .is_zero_o (b_zero),
        .is_sub_o  (b_sub),
        .is_inf_o  (b_inf),
        .is_nan_o  (b_nan)
    );

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [PROD_W-1:0]        mcand_q;   // A significand, shifted left STEP per cycle
    logic [BW-1:0]            mplier_q;  // B significand, shifted right STEP per cycle
    logic [PROD_W-1:0]        acc_q;
    logic                     sign_q;
    logic signed [EXPS_W-1:0] exp_q;     // ea + eb - bias
    logic                     special_q; // NaN/Inf operand seen
    logic                     zero_q;    // zero operand seen
    logic [FLEN-1:0]          res_q;
    logic                     down_valid_q;
    logic                     busy_q;
    logic                     error_q;

    logic                     accept_zero;
    logic [PROD_W-1:0]        pp_c;
    logic [FLEN-1:0]          res_d;
    logic                     err_d;

`ifdef F_MULT_ITER_SUBNORMAL_EN
    assign accept_zero = a_zero | b_zero;
`else
    assign accept_zero = a_zero | b_zero | a_sub | b_sub;
`endif

    // partial product for the current STEP multiplier bits
    always_comb begin
        pp_c = '0;
        for (int j = 0; j < int'(STEP); j++) begin
            if (mplier_q[j]) begin
                pp_c = pp_c + (mcand_q << j);
            end
        end
    end

    // normalise, round to nearest even, pack and apply special-case rules
    logic [PROD_W-1:0]        norm_sig;
    logic signed [EXPS_W-1:0] norm_exp;
    logic [PROD_W-1:0]        rnd_sig;
    logic [RE_W-1:0]          rnd_exp_m1;
    logic                     sticky_x;
    logic                     uflow;
    logic                     guard_b;
    logic                     sticky_b;
    logic                     round_up;
    logic [FLEN-1:0]          packed_c;
    logic                     ovf;
`ifdef F_MULT_ITER_SUBNORMAL_EN
    logic [6:0]               lz;
    logic [EXPS_W-1:0]        rsh;
`endif

    always_comb begin
        norm_sig   = acc_q;
        norm_exp   = exp_q;
        rnd_sig    = '0;
        rnd_exp_m1 = '0;
        sticky_x   = 1'b0;
        uflow      = 1'b0;
`ifdef F_MULT_ITER_SUBNORMAL_EN
        lz  = '0;
        rsh = '0;
        for (int i = 0; i < int'(PROD_W); i++) begin
            if (acc_q[i]) begin
                lz = 7'(int'(PROD_W) - 1 - i);
            end
        end
        norm_sig = acc_q << lz;
        norm_exp = exp_q + 13'sd1 - $signed({6'd0, lz});
        if (norm_exp < 13'sd1) begin
            // below the normal range: denormalise, keeping lost bits as sticky
            rsh = $unsigned(13'sd1 - norm_exp);
            if (rsh >= EXPS_W'(PROD_W)) begin
                rnd_sig  = '0;
                sticky_x = |norm_sig;
            end else begin
                rnd_sig  = norm_sig >> rsh;
                sticky_x = |(norm_sig & ~({PROD_W{1'b1}} << rsh));
            end
        end else begin
            rnd_sig    = norm_sig;
            rnd_exp_m1 = RE_W'(norm_exp - 13'sd1);
        end
`else
        // both significands are normal, so the product leads at bit 105 or 104
        if (acc_q[PROD_W-1]) begin
            norm_exp = exp_q + 13'sd1;
        end else begin
            norm_sig = acc_q << 1;
        end
        uflow      = (norm_exp < 13'sd1);
        rnd_sig    = norm_sig;
        rnd_exp_m1 = RE_W'(norm_exp - 13'sd1);
`endif
        guard_b  = rnd_sig[PROD_W-SIG_W-1];
        sticky_b = (|rnd_sig[PROD_W-SIG_W-2:0]) | sticky_x;
        round_up = guard_b & (sticky_b | rnd_sig[PROD_W-SIG_W]);
        // hidden bit adds into the exponent field; a rounding carry propagates naturally
        packed_c = {rnd_exp_m1, {FRAC_W{1'b0}}}
                 + FLEN'(rnd_sig[PROD_W-1 -: SIG_W])
                 + FLEN'(round_up);
        ovf      = (packed_c[FLEN-1 -: RE_W] >= RE_W'(2047));

        if (special_q) begin
            res_d = QNAN;
            err_d = 1'b1;
        end else if (zero_q || uflow) begin
            res_d = {sign_q, {(FLEN-1){1'b0}}};
            err_d = 1'b0;
        end else if (ovf) begin
            res_d = QNAN;
            err_d = 1'b1;
        end else begin
            res_d = {sign_q, packed_c[FLEN-2:0]};
            err_d = 1'b0;
        end
    end

    // sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            res_q        <= '0;
            down_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            down_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (up_valid) begin
                        mcand_q   <= PROD_W'(a_sig);
                        mplier_q  <= BW'(b_sig);
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        sign_q    <= a_sign ^ b_sign;
                        exp_q     <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp})
                                   - $signed(EXPS_W'(EXP_BIAS));
                        special_q <= a_nan | a_inf | b_nan | b_inf;
                        zero_q    <= accept_zero;
                        busy_q    <= 1'b1;
                        state_q   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_q + pp_c;
                    mcand_q  <= mcand_q << STEP;
                    mplier_q <= mplier_q >> STEP;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    res_q        <= res_d;
                    error_q      <= err_d;
                    down_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign res        = res_q;
    assign down_valid = down_valid_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule
